// File: rtl/hilotof_pkg.sv
// Shared constants and helpers for the hilotof result path.
// Used by hilotof_result_fifo and its storage sub-module.
`timescale 1ns/1ps
package hilotof_pkg;

    localparam int HILOTOF_WORD_W       = 32;
    localparam int HILOTOF_RESULT_DEPTH = 16;

    // Tells the output stage which register currently holds the head word.
    typedef enum logic {
        SRC_BYPASS = 1'b0,
        SRC_RAM    = 1'b1
    } hilotof_src_e;

    function automatic logic [7:0] hilotof_sat_inc8(input logic [7:0] value);
        hilotof_sat_inc8 = (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/hilotof_sdp_ram.sv
// Simple dual-port storage for the result FIFO: one write port and one
// registered read port. Contents are not reset.
`timescale 1ns/1ps
module hilotof_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [0:(1<<AW)-1];

    // Write port and registered read port; read data holds while rd_en is low.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/hilotof_result_fifo.sv
// Result FIFO with registered output stage and storage bypass.
// Optional overflow/drop accounting is built when HILOTOF_FIFO_OVF_EN is defined.
`timescale 1ns/1ps
module hilotof_result_fifo
    import hilotof_pkg::*;
#(
    parameter int WIDTH = HILOTOF_WORD_W,
    parameter int DEPTH = HILOTOF_RESULT_DEPTH
) (
    input  logic                     clock,
    input  logic                     sys_reset_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   STOR_FULL  = (AW + 1)'(DEPTH - 1);
    localparam logic [LW-1:0] LEVEL_ONE  = {{(LW-1){1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [LW-1:0]    level_r, level_next_s;
    logic             in_ready_r, in_ready_next_s;
    logic             out_valid_r, out_valid_next_s;
    hilotof_src_e     src_r, src_next_s;
    logic [WIDTH-1:0] byp_data_r, ram_rd_data_s;
    logic             push_s, pop_s, load_s, stor_empty_s;
    logic             ram_wr_en_s, ram_rd_en_s, byp_load_s;

    // Transfer decisions and next-state values for pointers, level and output stage.
    always_comb begin
        push_s           = in_valid && in_ready_r;
        pop_s            = out_valid_r && out_ready;
        stor_empty_s     = (wr_ptr_r == rd_ptr_r);
        load_s           = !out_valid_r || pop_s;
        ram_wr_en_s      = 1'b0;
        ram_rd_en_s      = 1'b0;
        byp_load_s       = 1'b0;
        out_valid_next_s = out_valid_r;
        src_next_s       = src_r;
        if (load_s && !stor_empty_s) begin
            ram_rd_en_s      = 1'b1;
            ram_wr_en_s      = push_s;
            out_valid_next_s = 1'b1;
            src_next_s       = SRC_RAM;
        end else if (load_s && push_s) begin
            byp_load_s       = 1'b1;
            out_valid_next_s = 1'b1;
            src_next_s       = SRC_BYPASS;
        end else if (load_s) begin
            out_valid_next_s = 1'b0;
        end else begin
            ram_wr_en_s      = push_s;
        end
        wr_ptr_next_s = ram_wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_next_s = ram_rd_en_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LEVEL_ONE;
            2'b01:   level_next_s = level_r - LEVEL_ONE;
            default: level_next_s = level_r;
        endcase
        // Full means the output stage is occupied and storage holds DEPTH-1 words.
        in_ready_next_s = !(out_valid_next_s && ((wr_ptr_next_s - rd_ptr_next_s) == STOR_FULL));
    end

    // State registers for pointers, level, ready and the output stage.
    always_ff @(posedge clock) begin
        if (!sys_reset_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            src_r       <= SRC_BYPASS;
            byp_data_r  <= '0;
        end else begin
            wr_ptr_r    <= wr_ptr_next_s;
            rd_ptr_r    <= rd_ptr_next_s;
            level_r     <= level_next_s;
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
            src_r       <= src_next_s;
            if (byp_load_s) begin
                byp_data_r <= in_data;
            end
        end
    end

    hilotof_sdp_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_wr_en_s && sys_reset_n),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (in_data),
        .rd_en   (ram_rd_en_s && sys_reset_n),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (ram_rd_data_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign out_data  = (src_r == SRC_RAM) ? ram_rd_data_s : byp_data_r;

`ifdef HILOTOF_FIFO_OVF_EN
    logic       overflow_r;
    logic [7:0] drop_count_r;
    logic       drop_s;

    assign drop_s = in_valid && !in_ready_r;

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clock) begin
        if (!sys_reset_n) begin
            overflow_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else if (drop_s) begin
            overflow_r   <= 1'b1;
            drop_count_r <= hilotof_sat_inc8(drop_count_r);
        end
    end

    assign overflow   = overflow_r;
    assign drop_count = drop_count_r;
`else
    assign overflow   = 1'b0;
    assign drop_count = 8'd0;
`endif

endmodule
